// File: rtl/i2s_sample_tx.sv
// ---------------------------------------------------------------------------
// i2s_sample_tx
//
// Philips I2S transmitter and bus master for a mono 32-bit sample stream.
// One word per frame is taken through a valid/ready handshake into a
// one-entry holding register. The word is sent MSB first on both the left
// and the right channel. BCLK and LRCLK are generated here.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rstn          asynchronous active-low reset
//   sample        32-bit two's-complement sample word
//   sample_valid  sample is presented this cycle
//   sample_ready  holding register empty (accept = valid && ready)
//   bclk          I2S bit clock (period 2*CLK_DIV clk cycles)
//   lrclk         I2S word select, 0 = left, 1 = right
//   sdata         I2S serial data, one BCLK delayed after each LRCLK edge
//   underrun      one-cycle pulse when a frame starts with nothing to send
// ---------------------------------------------------------------------------
module i2s_sample_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] sample,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic             bclk_reg, bclk_next;
    logic [5:0]       bit_cnt_reg, bit_cnt_next;
    logic             lrclk_reg, lrclk_next;
    logic             sdata_reg, sdata_next;
    logic             underrun_reg, underrun_next;
    logic [31:0]      cur_reg, cur_next;
    logic [31:0]      hold_reg, hold_next;
    logic             full_reg, full_next;

    logic             div_tc;
    logic             fall_evt;
    logic             frame_load;
    logic             accept;
    logic [5:0]       k_next;
    logic [4:0]       bit_idx;

    assign div_tc     = (div_cnt_reg == DIV_LAST);
    // bclk is high just before this toggle, so the toggle drives it low
    assign fall_evt   = div_tc && bclk_reg;
    assign frame_load = fall_evt && (bit_cnt_reg == 6'd63);
    assign accept     = sample_valid && !full_reg;
    assign k_next     = bit_cnt_reg + 6'd1;

    // Bit index into cur for the new slot position k:
    //   k=1..31 -> 32-k, k=32 -> 0, k=33..63 -> 64-k, k=0 -> 0 (old word LSB).
    // All four cases collapse to (-k) mod 32.
    assign bit_idx    = 5'd0 - k_next[4:0];

    always_comb begin
        div_cnt_next  = div_tc ? '0 : div_cnt_reg + DIV_W'(1);
        bclk_next     = div_tc ? ~bclk_reg : bclk_reg;
        bit_cnt_next  = bit_cnt_reg;
        lrclk_next    = lrclk_reg;
        sdata_next    = sdata_reg;
        underrun_next = 1'b0;
        cur_next      = cur_reg;
        hold_next     = hold_reg;
        full_next     = full_reg;

        if (fall_evt) begin
            bit_cnt_next = k_next;
            lrclk_next   = k_next[5];
            // cur_reg is still the old word here, which is what k=0 needs
            sdata_next   = cur_reg[bit_idx];
        end

        if (frame_load) begin
            if (full_reg) begin
                cur_next  = hold_reg;
                full_next = 1'b0;
            end else if (sample_valid) begin
                // Bypass: the word goes straight to the shifter and the
                // holding register stays empty.
                cur_next  = sample;
            end else begin
                // Nothing new: cur keeps the previous word and repeats it.
                underrun_next = 1'b1;
            end
        end else if (accept) begin
            hold_next = sample;
            full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_reg  <= '0;
            bclk_reg     <= 1'b0;
            bit_cnt_reg  <= 6'd63;
            lrclk_reg    <= 1'b0;
            sdata_reg    <= 1'b0;
            underrun_reg <= 1'b0;
            cur_reg      <= '0;
            hold_reg     <= '0;
            full_reg     <= 1'b0;
        end else begin
            div_cnt_reg  <= div_cnt_next;
            bclk_reg     <= bclk_next;
            bit_cnt_reg  <= bit_cnt_next;
            lrclk_reg    <= lrclk_next;
            sdata_reg    <= sdata_next;
            underrun_reg <= underrun_next;
            cur_reg      <= cur_next;
            hold_reg     <= hold_next;
            full_reg     <= full_next;
        end
    end

    assign sample_ready = !full_reg;
    assign bclk         = bclk_reg;
    assign lrclk        = lrclk_reg;
    assign sdata        = sdata_reg;
    assign underrun     = underrun_reg;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_sample_tx
//
// Self-checking bench for i2s_sample_tx with CLK_DIV=2. A frame-level model
// tracks the holding register and the word each frame must carry; a DAC-side
// receiver decodes the I2S stream on BCLK rising edges back into words.
// ---------------------------------------------------------------------------
module tb_i2s_sample_tx;

    localparam int CD         = 2;
    localparam int FRAME      = 128 * CD;
    localparam int FIRST_LOAD = 2 * CD;

    logic        clk          = 1'b0;
    logic        rstn         = 1'b0;
    logic [31:0] sample       = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    int n_cmp = 0;
    int n_err = 0;

    i2s_sample_tx #(.CLK_DIV(CD)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    // edge_n counts rising edges since reset release; frame loads happen at
    // edges FIRST_LOAD + j*FRAME.
    int          edge_n = 0;
    logic        m_full = 1'b0;
    logic [31:0] m_hold = '0;
    logic [31:0] m_cur  = '0;
    logic        exp_ur = 1'b0;
    logic [31:0] exp_q[$];

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            edge_n = 0;
            m_full = 1'b0;
            m_hold = '0;
            m_cur  = '0;
            exp_ur = 1'b0;
            exp_q.delete();
        end else begin
            edge_n = edge_n + 1;
            exp_ur = 1'b0;
            if (edge_n >= FIRST_LOAD && (edge_n - FIRST_LOAD) % FRAME == 0) begin
                if (m_full) begin
                    m_cur  = m_hold;
                    m_full = 1'b0;
                end else if (sample_valid) begin
                    m_cur = sample;
                end else begin
                    exp_ur = 1'b1;
                end
                exp_q.push_back(m_cur);   // left
                exp_q.push_back(m_cur);   // right
            end else if (sample_valid && !m_full) begin
                m_hold = sample;
                m_full = 1'b1;
            end
        end
    end

    // ---------------- DAC-side receiver ----------------
    // A word ends on the BCLK rise where LRCLK is seen changing: that bit is
    // the LSB of the previous channel.
    logic        bclk_d  = 1'b0;
    logic        prev_lr = 1'b0;
    logic [31:0] sr      = '0;
    int          nbits   = 0;
    logic [31:0] rx_q[$];

    initial forever begin
        @(negedge clk or negedge rstn);
        if (!rstn) begin
            bclk_d  = 1'b0;
            prev_lr = 1'b0;
            sr      = '0;
            nbits   = 0;
            rx_q.delete();
        end else begin
            if (bclk && !bclk_d) begin
                sr = {sr[30:0], sdata};
                if (lrclk != prev_lr) begin
                    if (nbits >= 31) rx_q.push_back(sr);
                    nbits = 0;
                end else begin
                    nbits++;
                end
                prev_lr = lrclk;
            end
            bclk_d = bclk;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] got_w[$];
    logic [31:0] want_w[$];

    // Moves decoded words and their model counterparts into got_w/want_w.
    task automatic collect_words();
        got_w.delete();
        want_w.delete();
        while (rx_q.size() > 0) begin
            got_w.push_back(rx_q.pop_front());
            if (exp_q.size() > 0) want_w.push_back(exp_q.pop_front());
            else want_w.push_back('x);
        end
    endtask

    // Leaves the caller just after the negedge on which rstn was released.
    task automatic do_reset();
        @(negedge clk);
        #1 rstn = 1'b0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Holds the word until accepted; called just after a negedge.
    task automatic push_sample(input logic [31:0] d, input int budget, output bit ok);
        ok = 1'b0;
        sample = d;
        sample_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (sample_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic exp_b;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_values: got {bclk,lrclk,sdata,underrun,ready}=%b, required 00001",
                     {bclk, lrclk, sdata, underrun, sample_ready});
        end
        rstn = 1'b1;
        for (int n = 1; n <= FIRST_LOAD + 2; n++) begin
            @(negedge clk);
            exp_b = ((n / CD) % 2) == 1;
            n_cmp++;
            if (bclk !== exp_b) begin
                n_err++;
                $display("FAIL reset_bclk_timing: cycle %0d got %b, required %b", n, bclk, exp_b);
            end
            n_cmp++;
            if (underrun !== (n == FIRST_LOAD)) begin
                n_err++;
                $display("FAIL reset_first_underrun: cycle %0d got %b, required %b", n, underrun, n == FIRST_LOAD);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_single_frame();
        bit   ok;
        int   f;
        logic exp_lr;
        int   target;
        do_reset();
        push_sample(32'hA500_0001, 10, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL single_accept: got no acceptance, required acceptance within 10 cycles");
        end
        target = FIRST_LOAD + FRAME + 2 * CD + 2;
        for (int c = 0; c < 2 * FRAME && edge_n < target; c++) begin
            @(negedge clk);
            f = edge_n / (2 * CD);
            exp_lr = (f == 0) ? 1'b0 : (((f - 1) % 64) >= 32);
            n_cmp++;
            if (lrclk !== exp_lr) begin
                n_err++;
                $display("FAIL single_lrclk: edge %0d got %b, required %b", edge_n, lrclk, exp_lr);
            end
            n_cmp++;
            if (underrun !== (edge_n == FIRST_LOAD + FRAME)) begin
                n_err++;
                $display("FAIL single_underrun: edge %0d got %b, required %b", edge_n, underrun,
                         edge_n == FIRST_LOAD + FRAME);
            end
        end
        #1 collect_words();
        n_cmp++;
        if (got_w.size() < 2) begin
            n_err++;
            $display("FAIL single_word_count: got %0d words, required >= 2", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < 2; i++) begin
            n_cmp++;
            if (got_w[i] !== 32'hA500_0001 || got_w[i] !== want_w[i]) begin
                n_err++;
                $display("FAIL single_word: word %0d got %h, required a5000001 (model %h)", i, got_w[i], want_w[i]);
            end
        end
        $display("test_single_frame: %0d words decoded", got_w.size());
    endtask

    task automatic test_back_to_back();
        bit   acc_pend;
        int   nacc;
        int   loads;
        logic exp_rdy;
        int   target;
        nacc = 0;
        do_reset();
        sample = 32'd1;
        sample_valid = 1'b1;
        target = FIRST_LOAD + 4 * FRAME + 8;
        for (int c = 0; c < 5 * FRAME && edge_n < target; c++) begin
            acc_pend = sample_ready;
            @(negedge clk);
            if (acc_pend) begin
                nacc++;
                sample = sample + 32'd1;
            end
            // With valid held high, ready is only seen in the cycle after a load
            exp_rdy = (edge_n >= FIRST_LOAD) && ((edge_n - FIRST_LOAD) % FRAME == 0);
            n_cmp++;
            if (sample_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL b2b_ready: edge %0d got %b, required %b", edge_n, sample_ready, exp_rdy);
            end
        end
        sample_valid = 1'b0;
        loads = (edge_n - FIRST_LOAD) / FRAME + 1;
        n_cmp++;
        if (nacc !== loads + 1) begin
            n_err++;
            $display("FAIL b2b_accept_count: got %0d accepted, required %0d", nacc, loads + 1);
        end
        #1 collect_words();
        n_cmp++;
        if (got_w.size() < 8) begin
            n_err++;
            $display("FAIL b2b_word_count: got %0d words, required >= 8", got_w.size());
        end
        for (int i = 0; i < got_w.size(); i++) begin
            n_cmp++;
            if (got_w[i] !== 32'(i / 2 + 1) || got_w[i] !== want_w[i]) begin
                n_err++;
                $display("FAIL b2b_word: word %0d got %h, required %h (model %h)", i, got_w[i], 32'(i / 2 + 1), want_w[i]);
            end
        end
        $display("test_back_to_back: %0d accepted, %0d words decoded", nacc, got_w.size());
    endtask

    task automatic test_bypass();
        int target;
        do_reset();
        for (int c = 0; c < 2 * FRAME && edge_n < FIRST_LOAD + FRAME - 1; c++) @(negedge clk);
        n_cmp++;
        if (edge_n != FIRST_LOAD + FRAME - 1 || sample_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_setup: edge %0d ready %b, required edge %0d ready 1", edge_n, sample_ready,
                     FIRST_LOAD + FRAME - 1);
        end
        sample = 32'h7FFF_FFFF;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        n_cmp++;
        if (underrun !== 1'b0 || sample_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_load: got underrun=%b ready=%b, required underrun=0 ready=1", underrun, sample_ready);
        end
        target = FIRST_LOAD + 2 * FRAME + 2 * CD + 2;
        for (int c = 0; c < 2 * FRAME && edge_n < target; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sample_ready !== 1'b1 || underrun !== exp_ur) begin
                n_err++;
                $display("FAIL bypass_follow: edge %0d got ready=%b underrun=%b, required ready=1 underrun=%b",
                         edge_n, sample_ready, underrun, exp_ur);
            end
        end
        #1 collect_words();
        n_cmp++;
        if (got_w.size() < 4) begin
            n_err++;
            $display("FAIL bypass_word_count: got %0d words, required >= 4", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < 4; i++) begin
            n_cmp++;
            if (got_w[i] !== ((i < 2) ? 32'h0 : 32'h7FFF_FFFF) || got_w[i] !== want_w[i]) begin
                n_err++;
                $display("FAIL bypass_word: word %0d got %h, required %h (model %h)", i, got_w[i],
                         (i < 2) ? 32'h0 : 32'h7FFF_FFFF, want_w[i]);
            end
        end
        $display("test_bypass: %0d words decoded", got_w.size());
    endtask

    task automatic test_underrun();
        bit   ok;
        int   pulses;
        logic exp_u;
        int   target;
        pulses = 0;
        do_reset();
        push_sample(32'h0000_0010, 10, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL underrun_accept: got no acceptance, required acceptance within 10 cycles");
        end
        target = FIRST_LOAD + 2 * FRAME + 2 * CD + 64 * CD + 4;
        for (int c = 0; c < 3 * FRAME && edge_n < target; c++) begin
            @(negedge clk);
            exp_u = (edge_n > FIRST_LOAD) && ((edge_n - FIRST_LOAD) % FRAME == 0);
            if (underrun === 1'b1) pulses++;
            n_cmp++;
            if (underrun !== exp_u) begin
                n_err++;
                $display("FAIL underrun_pulse: edge %0d got %b, required %b", edge_n, underrun, exp_u);
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_err++;
            $display("FAIL underrun_count: got %0d pulse cycles, required 2", pulses);
        end
        #1 collect_words();
        n_cmp++;
        if (got_w.size() < 5) begin
            n_err++;
            $display("FAIL underrun_word_count: got %0d words, required >= 5", got_w.size());
        end
        for (int i = 0; i < got_w.size(); i++) begin
            n_cmp++;
            if (got_w[i] !== 32'h10 || got_w[i] !== want_w[i]) begin
                n_err++;
                $display("FAIL underrun_word: word %0d got %h, required 00000010 (model %h)", i, got_w[i], want_w[i]);
            end
        end
        $display("test_underrun: %0d pulses, %0d words decoded", pulses, got_w.size());
    endtask

    task automatic test_reset_mid();
        bit   ok_a;
        bit   ok_b;
        logic exp_b;
        int   rst_edge;
        rst_edge = FIRST_LOAD + 40 * 2 * CD + 1;
        do_reset();
        push_sample(32'hCAFE_0001, 10, ok_a);
        push_sample(32'hBEEF_0002, 20, ok_b);
        n_cmp++;
        if (!ok_a || !ok_b) begin
            n_err++;
            $display("FAIL mid_accept: got accepted a=%b b=%b, required both 1", ok_a, ok_b);
        end
        for (int c = 0; c < FRAME && edge_n < rst_edge; c++) @(negedge clk);
        n_cmp++;
        if (edge_n != rst_edge || lrclk !== 1'b1 || sample_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pre_reset: edge %0d lrclk=%b ready=%b, required edge %0d lrclk=1 ready=0",
                     edge_n, lrclk, sample_ready, rst_edge);
        end
        #1 collect_words();
        n_cmp++;
        if (got_w.size() != 1 || got_w[0] !== 32'hCAFE_0001) begin
            n_err++;
            $display("FAIL mid_pre_word: got %0d words first %h, required 1 word cafe0001",
                     got_w.size(), (got_w.size() > 0) ? got_w[0] : 32'hx);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL mid_reset_values: got {bclk,lrclk,sdata,underrun,ready}=%b, required 00001",
                     {bclk, lrclk, sdata, underrun, sample_ready});
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int n = 1; n <= FIRST_LOAD + 32 * 2 * CD + 8; n++) begin
            @(negedge clk);
            if (n <= FIRST_LOAD + 2) begin
                exp_b = ((n / CD) % 2) == 1;
                n_cmp++;
                if (bclk !== exp_b) begin
                    n_err++;
                    $display("FAIL mid_bclk_timing: cycle %0d got %b, required %b", n, bclk, exp_b);
                end
            end
            n_cmp++;
            if (underrun !== (n == FIRST_LOAD)) begin
                n_err++;
                $display("FAIL mid_underrun: cycle %0d got %b, required %b", n, underrun, n == FIRST_LOAD);
            end
        end
        #1 collect_words();
        n_cmp++;
        if (got_w.size() < 1 || got_w[0] !== 32'h0 || got_w[0] !== want_w[0]) begin
            n_err++;
            $display("FAIL mid_post_word: got %0d words first %h, required first word 00000000",
                     got_w.size(), (got_w.size() > 0) ? got_w[0] : 32'hx);
        end
        $display("test_reset_mid: done");
    endtask

    task automatic test_random();
        bit acc_pend;
        int pct;
        int nacc;
        nacc = 0;
        acc_pend = 1'b0;
        pct = 100;
        do_reset();
        for (int c = 0; c < 6 * FRAME; c++) begin
            if (c % FRAME == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 0;
                    1: pct = 1;
                    2: pct = 5;
                    default: pct = 100;
                endcase
            end
            if (acc_pend) begin
                sample_valid = 1'b0;
                nacc++;
            end
            if (!sample_valid && $urandom_range(0, 99) < pct) begin
                sample_valid = 1'b1;
                sample = $urandom;
            end
            acc_pend = sample_valid && sample_ready;
            @(negedge clk);
            n_cmp++;
            if (sample_ready !== !m_full) begin
                n_err++;
                $display("FAIL rand_ready: edge %0d got %b, required %b", edge_n, sample_ready, !m_full);
            end
            n_cmp++;
            if (underrun !== exp_ur) begin
                n_err++;
                $display("FAIL rand_underrun: edge %0d got %b, required %b", edge_n, underrun, exp_ur);
            end
        end
        sample_valid = 1'b0;
        #1 collect_words();
        n_cmp++;
        if (got_w.size() < 10) begin
            n_err++;
            $display("FAIL rand_word_count: got %0d words, required >= 10", got_w.size());
        end
        for (int i = 0; i < got_w.size(); i++) begin
            n_cmp++;
            if (got_w[i] !== want_w[i]) begin
                n_err++;
                $display("FAIL rand_word: word %0d got %h, required %h", i, got_w[i], want_w[i]);
            end
        end
        $display("test_random: %0d accepted, %0d words decoded", nacc, got_w.size());
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bypass();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_sample_tx.md
# i2s_sample_tx

Serializes the 32-bit mono sample stream produced by the signal generator/mixer into a standard Philips I2S bitstream for an external audio DAC. Accepts one sample per frame through a valid/ready handshake into a one-entry holding register. Sends the same word on the left and right channels. Generates BCLK and LRCLK itself as the bus master, and flags a one-cycle underrun when no new sample is available at a frame boundary.

## Interface
- CLK_DIV, 4, clk cycles per BCLK half-period; must be >= 1
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- sample  in  32  two's-complement sample word, sent MSB first
- sample_valid  in  1  sample is presented this cycle
- sample_ready  out  1  holding register is empty; a sample is accepted when sample_valid && sample_ready
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select; 0 = left, 1 = right
- sdata  out  1  I2S serial data
- underrun  out  1  one-cycle pulse when a frame starts with an empty holding register

## Operation
- Reset values: bclk=0, lrclk=0, sdata=0, sample_ready=1, underrun=0. Internal state on reset: div_cnt=0, bit_cnt=63, cur=0, holding empty.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At terminal count it wraps to 0 and bclk toggles.
  - A toggle 1->0 is a "fall event"; a toggle 0->1 is a "rise event".
- Frame: 64 BCLK periods, indexed by bit_cnt 0..63. bit_cnt increments modulo 64 on each fall event.
- Outputs are registered and update only on fall events. With k = the new bit_cnt:
  - lrclk = 1 for k in 32..63, else 0.
  - k=0: sdata = cur[0] of the old word (right-channel LSB of the previous frame).
  - k=1..31: sdata = cur[32-k] (left channel, MSB at k=1).
  - k=32: sdata = cur[0] (left LSB).
  - k=33..63: sdata = cur[64-k] (right channel, MSB at k=33).
  - This gives the standard one-BCLK data delay after each LRCLK edge.
- Frame load (the fall event where bit_cnt goes 63->0):
  - First, sdata takes the old cur[0].
  - Then, if the holding register is full: cur <= holding and the holding register empties.
  - Else, if sample_valid is high in that same cycle: cur <= sample (bypass). The sample counts as accepted, the holding register stays empty, and there is no underrun.
  - Else: cur is unchanged (the last sample repeats) and underrun=1 for exactly that clk cycle.
- Handshake:
  - sample_ready = holding empty; it is combinational from the flag only, never from sample_valid.
  - An accepted sample is written to holding unless it is consumed by the bypass above.
  - sample_valid while not ready is ignored; the source must hold the sample.
  - At most one sample is consumed per frame.
- Reset mid-frame: all outputs return to reset values asynchronously and the pending holding word is discarded. The first fall event after release starts a new frame at k=0.

## Timing
- BCLK period = 2*CLK_DIV clk cycles. Frame = 128*CLK_DIV clk cycles. Sample rate = f_clk/(128*CLK_DIV).
- First rise event: CLK_DIV cycles after reset release. First fall event (frame load, k=0): 2*CLK_DIV cycles after release.
- Latency: a sample accepted into an empty holding register at cycle t reaches sdata (MSB) one BCLK after the next frame load.
- sample_ready falls the cycle after acceptance and rises the cycle after a frame load that empties holding.
- underrun is asserted the cycle after the load event and for one cycle only.
- sdata and lrclk change only on the clk edge that drives bclk low, so they are stable across the bclk rising edge.

## Test plan
- Reset check (CLK_DIV=2): hold rstn low, then release -> bclk=lrclk=sdata=0 and sample_ready=1. First bclk rise occurs 2 cycles after release and the first fall 4 cycles after; underrun pulses at that first fall (holding empty).
- Single frame (CLK_DIV=2): present 0xA5000001 before the first fall. Required:
  - lrclk low for 32 BCLKs, then high for 32.
  - Left slot on sdata (k=1..32) = 1010_0101_0000…0001 MSB-first.
  - Right slot (k=33..63 plus k=0 of the next frame) repeats the same word.
  - No underrun in that frame.
- Back-pressure: hold sample_valid high with incrementing data 1,2,3… -> exactly one sample accepted per frame, sample_ready low between loads, and transmitted words are 1,2,3 with none skipped.
- Bypass: holding empty, and sample_valid asserts with 0x7FFFFFFF only in the load cycle -> the word is transmitted in that frame, underrun stays 0, and sample_ready remains 1.
- Underrun: send 0x00000010, then no more samples -> the next frame repeats 0x00000010 on both channels and underrun pulses for 1 cycle at each subsequent frame load.
- Reset mid-frame: assert rstn at k=40 with holding full -> outputs go to reset values immediately; after release the pending word is gone (first load underruns) and timing restarts as in the reset check.
